// File: rtl/wave_play_sched_pkg.sv
// Shared encodings for the waveform RAM scheduler: FSM states and RAM-read owner.
package wave_play_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PLAY = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    localparam int DAC_W = 15;

endpackage

// File: rtl/wave_tick_div.sv
// Sample-rate divider: counts 0..period while enabled and pulses tick on the wrap cycle.
module wave_tick_div #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == period);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/wave_play_sched.sv
// Shares the single-port waveform RAM between host accesses and rate-timed playback,
// registering each fetched sample onto the DAC bus.
module wave_play_sched
    import wave_play_sched_pkg::*;
#(
    parameter int ADR_W = 17,
    parameter int DAT_W = 16,
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_start,
    input  logic             cfg_stop,
    input  logic [ADR_W-1:0] cfg_end_adr,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [ADR_W-1:0] host_adr,
    input  logic [DAT_W-1:0] host_wdata,
    output logic             host_ack,
    output logic [DAT_W-1:0] host_rdata,
    output logic             host_rvalid,
    output logic [ADR_W-1:0] ram_adr,
    output logic [DAT_W-1:0] ram_wdata,
    output logic             ram_we,
    input  logic [DAT_W-1:0] ram_rdata,
    output logic [DAC_W-1:0] dac_data,
    output logic             dac_strobe,
    output logic             running,
    output logic [ADR_W-1:0] play_adr,
    output logic             host_stall
);

    state_t           state;
    owner_t           owner;
    logic [ADR_W-1:0] end_q;
    logic [DIV_W-1:0] div_q;
    logic             alive;
    logic             div_en;
    logic             tick;
    logic             play_rd;
    logic             host_gnt;
    logic             restart;

    assign div_en = (state == ST_RUN);

    wave_tick_div #(.DIV_W(DIV_W)) u_tick_div (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (!div_en),
        .en     (div_en),
        .period (div_q),
        .tick   (tick)
    );

    // alive keeps the combinational grant quiet while reset is held
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            alive <= 1'b0;
        else
            alive <= 1'b1;
    end

    assign play_rd  = (state == ST_PRIME) || tick;
    assign host_gnt = alive && host_req && !play_rd;
    assign restart  = cfg_start && !cfg_stop && (state != ST_PRIME);

    assign host_ack    = host_gnt;
    assign host_stall  = alive && host_req && !host_gnt;
    assign host_rvalid = (owner == OWN_HOST);
    assign host_rdata  = host_rvalid ? ram_rdata : '0;
    assign dac_strobe  = (owner == OWN_PLAY);

    always_comb begin
        ram_adr   = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        if (play_rd) begin
            ram_adr = play_adr;
        end else if (host_gnt) begin
            ram_adr   = host_adr;
            ram_wdata = host_wdata;
            ram_we    = host_we;
        end
    end

    // owner steers the next cycle's ram_rdata to the DAC or the host
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner    <= OWN_NONE;
            dac_data <= '0;
        end else begin
            if (play_rd)
                owner <= OWN_PLAY;
            else if (host_gnt && !host_we)
                owner <= OWN_HOST;
            else
                owner <= OWN_NONE;
            if (owner == OWN_PLAY)
                dac_data <= ram_rdata[DAC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            running  <= 1'b0;
            play_adr <= '0;
            end_q    <= '0;
            div_q    <= '0;
        end else begin
            if (play_rd)
                play_adr <= (play_adr == end_q) ? '0 : play_adr + 1'b1;
            case (state)
                ST_IDLE:  running <= 1'b0;
                ST_PRIME: begin
                    state   <= cfg_stop ? ST_IDLE : ST_RUN;
                    running <= !cfg_stop;
                end
                ST_RUN: if (cfg_stop) begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
            if (restart) begin
                state    <= ST_PRIME;
                running  <= 1'b1;
                play_adr <= '0;
                end_q    <= cfg_end_adr;
                div_q    <= cfg_div;
            end
        end
    end

endmodule

// File: tb/tb_wave_play_sched.sv
// Randomized scoreboard bench for wave_play_sched with a behavioural RAM and playback model.
module tb_wave_play_sched;

    localparam int ADR_W = 17;
    localparam int DAT_W = 16;
    localparam int DIV_W = 32;

    logic             clk;
    logic             rstn;
    logic             cfg_start, cfg_stop;
    logic [ADR_W-1:0] cfg_end_adr;
    logic [DIV_W-1:0] cfg_div;
    logic             host_req, host_we;
    logic [ADR_W-1:0] host_adr;
    logic [DAT_W-1:0] host_wdata;
    logic             host_ack;
    logic [DAT_W-1:0] host_rdata;
    logic             host_rvalid;
    logic [ADR_W-1:0] ram_adr;
    logic [DAT_W-1:0] ram_wdata;
    logic             ram_we;
    logic [DAT_W-1:0] ram_rdata;
    logic [14:0]      dac_data;
    logic             dac_strobe;
    logic             running;
    logic [ADR_W-1:0] play_adr;
    logic             host_stall;

    wave_play_sched #(.ADR_W(ADR_W), .DAT_W(DAT_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_end_adr(cfg_end_adr), .cfg_div(cfg_div),
        .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .ram_adr(ram_adr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .dac_data(dac_data), .dac_strobe(dac_strobe), .running(running),
        .play_adr(play_adr), .host_stall(host_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port RAM, one cycle read latency
    logic [DAT_W-1:0] ram [0:(1<<ADR_W)-1];
    logic [DAT_W-1:0] ram_q;
    always @(posedge clk) begin
        if (ram_we) ram[ram_adr] <= ram_wdata;
        ram_q <= ram[ram_adr];
    end
    assign ram_rdata = ram_q;

    // Reference contents as the host has written them
    logic [DAT_W-1:0] ref_mem [0:(1<<ADR_W)-1];
    logic [DAT_W-1:0] hq [$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Playback model: next fetch address, latched end/period, strobe spacing
    logic [ADR_W-1:0] exp_padr = '0;
    logic [ADR_W-1:0] m_end = '0;
    logic [DIV_W-1:0] m_div = '0;
    int               cyc = 0;
    int               last_t = 0;
    bit               have_last = 0;
    bit               pend = 0;
    logic [14:0]      pend_exp = '0;

    initial begin
        logic [DAT_W-1:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                pend = 0;
                have_last = 0;
            end else begin
                if (pend) chk("dac_data", {17'd0, dac_data}, {17'd0, pend_exp});
                pend = 0;
                if (dac_strobe) begin
                    pend      = 1;
                    pend_exp  = ref_mem[exp_padr][14:0];
                    exp_padr  = (exp_padr == m_end) ? '0 : exp_padr + 1;
                    chk("play_adr", {15'd0, play_adr}, {15'd0, exp_padr});
                    if (have_last) chk("strobe_gap", cyc - last_t, m_div + 32'd1);
                    have_last = 1;
                    last_t    = cyc;
                end
                if (host_rvalid) begin
                    if (hq.size() == 0) begin
                        chk("host_rvalid_unexpected", {31'd0, host_rvalid}, 32'd0);
                    end else begin
                        e = hq.pop_front();
                        chk("host_rdata", {16'd0, host_rdata}, {16'd0, e});
                    end
                end
                if (cfg_start && !cfg_stop) begin
                    exp_padr  = '0;
                    m_end     = cfg_end_adr;
                    m_div     = cfg_div;
                    have_last = 0;
                end
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_host_ack"},    {31'd0, host_ack}, 0);
        chk({tag, "_host_rdata"},  {16'd0, host_rdata}, 0);
        chk({tag, "_host_rvalid"}, {31'd0, host_rvalid}, 0);
        chk({tag, "_ram_adr"},     {15'd0, ram_adr}, 0);
        chk({tag, "_ram_wdata"},   {16'd0, ram_wdata}, 0);
        chk({tag, "_ram_we"},      {31'd0, ram_we}, 0);
        chk({tag, "_dac_data"},    {17'd0, dac_data}, 0);
        chk({tag, "_dac_strobe"},  {31'd0, dac_strobe}, 0);
        chk({tag, "_running"},     {31'd0, running}, 0);
        chk({tag, "_play_adr"},    {15'd0, play_adr}, 0);
        chk({tag, "_host_stall"},  {31'd0, host_stall}, 0);
    endtask

    task automatic host_op(input logic we, input logic [ADR_W-1:0] adr, input logic [DAT_W-1:0] wd);
        int t;
        @(posedge clk); #1;
        host_req = 1'b1; host_we = we; host_adr = adr; host_wdata = wd;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!host_ack && t < 64);
        chk("host_ack", {31'd0, host_ack}, 32'd1);
        if (host_ack) begin
            if (we) ref_mem[adr] = wd;
            else    hq.push_back(ref_mem[adr]);
        end
        @(posedge clk); #1;
        host_req = 1'b0;
    endtask

    task automatic pulse(input logic st, input logic sp);
        @(posedge clk); #1;
        cfg_start = st; cfg_stop = sp;
        @(posedge clk); #1;
        cfg_start = 1'b0; cfg_stop = 1'b0;
    endtask

    task automatic wait_strobe(input string nm);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!dac_strobe && t < 64);
        chk(nm, {31'd0, dac_strobe}, 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; cfg_start = 0; cfg_stop = 0; cfg_end_adr = '0; cfg_div = '0;
        host_req = 1'b1; host_we = 1'b1; host_adr = 17'd5; host_wdata = 16'hAAAA;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        host_req = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;

        // Basic playback of four samples, div=2, wrap 3 -> 0
        for (int i = 0; i < 16; i++)
            host_op(1'b1, i[ADR_W-1:0], (i < 4) ? 16'((i + 1) * 16'h11) : 16'($urandom));
        cfg_end_adr = 17'd3; cfg_div = 32'd2;
        pulse(1'b1, 1'b0);
        cfg_end_adr = 17'd9; cfg_div = 32'd7;   // ignored until next start
        repeat (26) @(posedge clk);
        @(negedge clk) chk("running_t1", {31'd0, running}, 32'd1);
        pulse(1'b0, 1'b1);
        repeat (6) @(negedge clk);
        chk("stopped_t1", {31'd0, running}, 32'd0);

        // Host starved at div=0, granted in first IDLE cycle
        cfg_end_adr = 17'd1; cfg_div = 32'd0;
        pulse(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1 host_req = 1'b1; host_we = 1'b1; host_adr = 17'd9; host_wdata = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_hi", {31'd0, host_stall}, 32'd1);
            chk("no_ack", {31'd0, host_ack}, 32'd0);
        end
        @(posedge clk); #1 cfg_stop = 1'b1;
        @(negedge clk) chk("ack_on_stop_cycle", {31'd0, host_ack}, 32'd0);
        @(posedge clk); #1 cfg_stop = 1'b0;
        @(negedge clk) chk("ack_first_idle", {31'd0, host_ack}, 32'd1);
        ref_mem[9] = 16'hBEEF;
        @(posedge clk); #1 host_req = 1'b0;
        repeat (4) @(posedge clk);

        // div=4: host read colliding with a tick, then ordinary reads
        cfg_end_adr = 17'd3; cfg_div = 32'd4;
        pulse(1'b1, 1'b0);
        wait_strobe("strobe_seen");
        repeat (4) @(posedge clk);
        #1 host_req = 1'b1; host_we = 1'b0; host_adr = 17'd3;
        @(negedge clk);
        chk("tick_beats_host", {31'd0, host_ack}, 32'd0);
        chk("tick_stall", {31'd0, host_stall}, 32'd1);
        @(negedge clk);
        chk("ack_after_tick", {31'd0, host_ack}, 32'd1);
        if (host_ack) hq.push_back(ref_mem[3]);
        @(posedge clk); #1 host_req = 1'b0;
        @(negedge clk) chk("rvalid_lat", {31'd0, host_rvalid}, 32'd1);
        for (int i = 0; i < 4; i++) host_op(1'b0, 17'($urandom_range(0, 15)), '0);
        pulse(1'b0, 1'b1);
        repeat (6) @(posedge clk);

        // stop+start together: stop wins, play_adr holds; start alone restarts
        cfg_end_adr = 17'd3; cfg_div = 32'd2;
        pulse(1'b1, 1'b0);
        repeat ($urandom_range(5, 15)) @(posedge clk);
        pulse(1'b1, 1'b1);
        @(negedge clk) chk("stop_wins", {31'd0, running}, 32'd0);
        repeat (4) @(negedge clk);
        chk("play_adr_hold", {15'd0, play_adr}, {15'd0, exp_padr});
        pulse(1'b1, 1'b0);
        wait_strobe("restart_strobe");
        repeat (10) @(posedge clk);
        pulse(1'b0, 1'b1);
        repeat (6) @(posedge clk);

        // Randomized runs with concurrent host traffic
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 2; i++)
                host_op(1'b1, 17'($urandom_range(0, 7)), 16'($urandom));
            cfg_end_adr = (r == 0) ? 17'd0 : 17'($urandom_range(0, 7));
            cfg_div = 32'($urandom_range(1, 3));
            pulse(1'b1, 1'b0);
            for (int i = 0; i < 6; i++) begin
                if ($urandom_range(0, 1) == 1)
                    host_op(1'b1, 17'($urandom_range(8, 15)), 16'($urandom));
                else
                    host_op(1'b0, 17'($urandom_range(0, 15)), '0);
                repeat ($urandom_range(0, 4)) @(posedge clk);
            end
            pulse(1'b0, 1'b1);
            repeat (8) @(posedge clk);
        end

        // Async reset mid-run with a stalled host read
        cfg_end_adr = 17'd1; cfg_div = 32'd0;
        pulse(1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1 host_req = 1'b1; host_we = 1'b0; host_adr = 17'd2;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk_zero("async_rst");
        host_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_rvalid", {31'd0, host_rvalid}, 32'd0);
            chk("post_rst_strobe", {31'd0, dac_strobe}, 32'd0);
        end
        chk("hq_drained", hq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wave_play_sched.md
Name: wave_play_sched

Overview:
Controls the single-port waveform RAM that holds DAC samples and shares it between two users: the UART command FSM, which does host writes and single reads, and the playback engine, which reads samples at a programmable rate. The block generates the sample tick, walks the address from 0 to a programmable end address with wrap-around, and registers each fetched sample onto the 15-bit DAC data bus. It sits between the command decoder, the RAM and the SDR output register.

Parameters:
ADR_W, 17, RAM address width
DAT_W, 16, RAM word width; DAC sample is bits [14:0]
DIV_W, 32, sample-rate divider width

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse: begin playback from address 0
cfg_stop  in  1  one-cycle pulse: end playback
cfg_end_adr  in  ADR_W  last playback address (inclusive)
cfg_div  in  DIV_W  sample period = cfg_div+1 clk cycles
host_req  in  1  host access request; held until host_ack
host_we  in  1  1=write, 0=read; stable while host_req
host_adr  in  ADR_W  host address
host_wdata  in  DAT_W  host write data
host_ack  out  1  one-cycle grant pulse
host_rdata  out  DAT_W  host read data
host_rvalid  out  1  one-cycle pulse, host_rdata valid
ram_adr  out  ADR_W  RAM address
ram_wdata  out  DAT_W  RAM write data
ram_we  out  1  RAM write enable
ram_rdata  in  DAT_W  RAM read data, 1-cycle latency
dac_data  out  15  current DAC sample
dac_strobe  out  1  one-cycle pulse when dac_data updates
running  out  1  playback active
play_adr  out  ADR_W  address of the next playback fetch
host_stall  out  1  high while host_req is pending and not granted

Behaviour:
- Reset values: all outputs 0. State IDLE. Divider counter 0. Latched end address 0.
- States:
  - IDLE: on cfg_start, latch cfg_end_adr and cfg_div, set play_adr=0, clear the divider counter, go to PRIME.
  - PRIME: issue a playback read of address 0 in this cycle, then go to RUN.
  - RUN: cfg_stop returns to IDLE next cycle. A pending playback read still completes and updates dac_data.
  - cfg_start in RUN restarts the sequence (same as from IDLE).
  - cfg_stop and cfg_start in the same cycle: cfg_stop wins.
  - cfg_start in PRIME is ignored.
- Tick: in RUN, the divider counts 0..div_latched and asserts tick when it wraps to 0. Counting starts at entry to RUN. With div=0 there is a tick every cycle.
- Playback fetch:
  - On a tick, a playback read of play_adr is issued.
  - play_adr advances to play_adr+1, or to 0 when play_adr==end_latched.
  - If end_latched is 0, address 0 is read on every tick.
- Read return: in the cycle after any playback read, dac_data<=ram_rdata[14:0] and dac_strobe=1. Latency from tick to dac_strobe is exactly 1 cycle.
- Arbitration, one RAM access per cycle:
  - Playback (PRIME or tick) has strict priority.
  - The host is granted in any cycle without a playback access. host_ack pulses in the same cycle ram_adr=host_adr.
  - Host write: ram_we=1 for that cycle.
  - Host read: host_rdata and host_rvalid follow 1 cycle later. ram_rdata is steered to the host or to the DAC by a registered owner bit.
- host_req sampled with host_ack high is consumed. The requester drops host_req or presents a new request in the next cycle.
- With running and div=0 the host is never granted. host_stall stays high; this is the defined behaviour and there is no timeout.
- Host write to the address being fetched in the same cycle cannot occur (playback has priority). Writes during RUN take effect at the next pass.
- cfg_div and cfg_end_adr changes during RUN are ignored until the next cfg_start.
- Asynchronous reset mid-operation aborts immediately to the reset values. A pending host access is dropped without host_ack.

Decomposition:
- Shared package: state encoding (IDLE=0, PRIME=1, RUN=2) and the 2-bit owner encoding (NONE, PLAY, HOST).
- One sub-module, wave_tick_div: loadable DIV_W counter with clear, enable and a tick pulse on wrap.

Test Plan:
- Reset, then load RAM[0..3]=0x0011,0x0022,0x0033,0x0044 via host writes, end=3, div=2, start → dac_data 0x11, 0x22, 0x33, 0x44, 0x11... with a dac_strobe every 3 cycles; play_adr wraps 3→0.
- div=0, end=1, start, hold a host write request → host_stall stays high with no host_ack. Stop → host_ack in the cycle after IDLE is entered.
- div=4, running, host read of address 3 (data 0x0044) → host_rvalid 1 cycle after host_ack with host_rdata=0x0044, and no corruption of dac_data.
- A host request coinciding with a tick → the playback fetch takes the RAM, host_ack arrives the next cycle.
- cfg_stop and cfg_start in the same cycle → running drops and play_adr does not reset. A later cfg_start alone restarts from address 0.
- Assert rstn low mid-RUN with a host read outstanding → all outputs 0 immediately, and no host_rvalid after release.
